// File: rtl/hsv_pipe_arbiter_pkg.sv
// Shared constants and tracking record for the rgb2hsv pipeline arbiter.
// Channel widths and the default core latency live here so the core wrapper and arbiter agree.
package hsv_pkg;

    localparam int unsigned HSV_PIPE_LAT = 22;
    localparam int unsigned HSV_CH_W     = 8;
    localparam int unsigned HSV_PIX_W    = 3 * HSV_CH_W;
    localparam int unsigned HSV_TAG_W    = 20;

    // Default-width form of the per-sample tracking record.
    typedef struct packed {
        logic                 valid;
        logic                 id;
        logic [HSV_TAG_W-1:0] tag;
    } hsv_trk_t;

endpackage

// File: rtl/hsv_pipe_arbiter_if.sv
// Requester, core and result signals of the rgb2hsv pipeline arbiter.
// master is the arbiter side; slave is the surrounding system (requesters, core, consumer).
interface hsv_pipe_arbiter_if
    import hsv_pkg::*;
#(
    parameter int unsigned TAG_W = HSV_TAG_W,
    parameter int unsigned CNT_W = 5
);

    logic                 pause;
    logic                 req0_valid;
    logic                 req0_ready;
    logic [HSV_PIX_W-1:0] req0_rgb;
    logic [TAG_W-1:0]     req0_tag;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [HSV_PIX_W-1:0] req1_rgb;
    logic [TAG_W-1:0]     req1_tag;
    logic [HSV_CH_W-1:0]  core_r, core_g, core_b;
    logic [HSV_CH_W-1:0]  core_h, core_s, core_v;
    logic                 out_valid;
    logic                 out_id;
    logic [TAG_W-1:0]     out_tag;
    logic [HSV_PIX_W-1:0] out_hsv;
    logic [CNT_W-1:0]     in_flight;
    logic                 idle;

    modport master (
        input  pause, req0_valid, req0_rgb, req0_tag, req1_valid, req1_rgb, req1_tag,
               core_h, core_s, core_v,
        output req0_ready, req1_ready, core_r, core_g, core_b,
               out_valid, out_id, out_tag, out_hsv, in_flight, idle
    );

    modport slave (
        output pause, req0_valid, req0_rgb, req0_tag, req1_valid, req1_rgb, req1_tag,
               core_h, core_s, core_v,
        input  req0_ready, req1_ready, core_r, core_g, core_b,
               out_valid, out_id, out_tag, out_hsv, in_flight, idle
    );

endinterface

// File: rtl/hsv_tag_delay.sv
// Fixed-depth shift register with synchronous clear; carries sample metadata
// alongside the non-stallable rgb2hsv core.
module hsv_tag_delay #(
    parameter int unsigned DEPTH = 23,
    parameter int unsigned WIDTH = 22
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/hsv_pipe_arbiter.sv
// Round-robin share of one fixed-latency rgb2hsv core between the camera stream (0)
// and the colour-probe sampler (1); results return tagged with owner and tag, in issue order.
module hsv_pipe_arbiter
    import hsv_pkg::*;
#(
    parameter int unsigned PIPE_LAT = HSV_PIPE_LAT,
    parameter int unsigned TAG_W    = HSV_TAG_W,
    parameter int unsigned CNT_W    = 5
) (
    input  logic               clock,
    input  logic               reset,
    hsv_pipe_arbiter_if.master bus
);

    typedef struct packed {
        logic             valid;
        logic             id;
        logic [TAG_W-1:0] tag;
    } trk_t;

    logic                 grant0, grant1, xfer;
    logic                 last_grant_q, last_grant_d;
    logic [HSV_PIX_W-1:0] core_rgb_q, core_rgb_d;
    trk_t                 trk_in, trk_tail;
    logic                 out_valid_q, out_valid_d;
    logic                 out_id_q, out_id_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;
    logic [HSV_PIX_W-1:0] out_hsv_q, out_hsv_d;
    logic [CNT_W-1:0]     in_flight_q, in_flight_d;

    // Grant uses only valids, pause and the pointer, so neither ready loops through the other.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && !bus.pause) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign xfer           = grant0 || grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        last_grant_d = xfer ? grant1 : last_grant_q;
        core_rgb_d   = '0;
        trk_in       = '0;
        if (xfer) begin
            core_rgb_d   = grant1 ? bus.req1_rgb : bus.req0_rgb;
            trk_in.valid = 1'b1;
            trk_in.id    = grant1;
            trk_in.tag   = grant1 ? bus.req1_tag : bus.req0_tag;
        end
    end

    hsv_tag_delay #(
        .DEPTH (PIPE_LAT + 1),
        .WIDTH ($bits(trk_t))
    ) u_trk (
        .clk  (clock),
        .clr  (reset),
        .din  (trk_in),
        .dout (trk_tail)
    );

    always_comb begin
        out_valid_d = trk_tail.valid;
        out_id_d    = out_id_q;
        out_tag_d   = out_tag_q;
        out_hsv_d   = out_hsv_q;
        if (trk_tail.valid) begin
            out_id_d  = trk_tail.id;
            out_tag_d = trk_tail.tag;
            out_hsv_d = {bus.core_h, bus.core_s, bus.core_v};
        end
        in_flight_d = in_flight_q;
        if (xfer && !trk_tail.valid) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (!xfer && trk_tail.valid) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            core_rgb_q   <= '0;
            out_valid_q  <= 1'b0;
            out_id_q     <= 1'b0;
            out_tag_q    <= '0;
            out_hsv_q    <= '0;
            in_flight_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            core_rgb_q   <= core_rgb_d;
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_tag_q    <= out_tag_d;
            out_hsv_q    <= out_hsv_d;
            in_flight_q  <= in_flight_d;
        end
    end

    assign {bus.core_r, bus.core_g, bus.core_b} = core_rgb_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_hsv   = out_hsv_q;
    assign bus.in_flight = in_flight_q;
    assign bus.idle      = (in_flight_q == '0) && !xfer;

endmodule

// File: doc/hsv_pipe_arbiter.md
Name: hsv_pipe_arbiter

Overview:
- Shares one fixed-latency, non-stallable rgb2hsv pipeline between two pixel requesters.
- Requester 0 is the live camera pixel stream. Requester 1 is the calibration/colour-probe sampler.
- Grants at most one RGB sample per cycle and tracks each sample's owner and tag through the core latency.
- Returns HSV results tagged with owner and tag. Sits between the video front-end and the colour-threshold/blob logic.

Parameters:
- PIPE_LAT, 22: cycles from core_r/g/b presented to the matching core_h/s/v; must equal the core's latency.
- TAG_W, 20: requester tag width (pixel x/y or probe index).
- CNT_W, 5: in-flight counter width; requires 2^CNT_W > PIPE_LAT.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- pause  in  1  when high, no new grants; in-flight samples still drain
- req0_valid  in  1  requester 0 has a sample
- req0_ready  out  1  grant to requester 0 (combinational)
- req0_rgb  in  24  {r,g,b}, 8 bits each
- req0_tag  in  TAG_W  requester 0 tag
- req1_valid  in  1  requester 1 has a sample
- req1_ready  out  1  grant to requester 1 (combinational)
- req1_rgb  in  24  {r,g,b}
- req1_tag  in  TAG_W  requester 1 tag
- core_r, core_g, core_b  out  8 each  registered inputs to the rgb2hsv core
- core_h, core_s, core_v  in  8 each  core outputs
- out_valid  out  1  result valid, one-cycle pulse per sample
- out_id  out  1  owner of the result (0 or 1)
- out_tag  out  TAG_W  tag of the sample
- out_hsv  out  24  {h,s,v}
- in_flight  out  CNT_W  samples accepted but not yet returned
- idle  out  1  high when in_flight == 0 and no grant this cycle

Behaviour:
- Handshake:
  - A sample transfers on a rising edge when reqN_valid && reqN_ready.
  - reqN_ready depends only on pause, both valid inputs and the RR pointer; it never depends on ready of the other requester.
  - At most one ready is high per cycle. With pause high, both readies are low.
- Arbitration:
  - Two-state round-robin pointer, last_grant ∈ {0,1}, reset value 1 (so requester 0 wins first).
  - Only one valid: that requester is granted.
  - Both valid: grant the requester != last_grant.
  - last_grant updates only on an actual transfer.
- Datapath issue:
  - On a transfer edge, core_r/g/b are loaded with the granted rgb.
  - On a non-transfer edge, core_r/g/b load 0. This is a don't-care for the core, but fixed for determinism.
- Tracking:
  - Shift register of {valid, id, tag}, depth PIPE_LAT+1.
  - Stage 0 is loaded on the same edge as core_r/g/b (valid = transfer).
  - Every stage shifts each cycle; no stalls exist anywhere.
- Output:
  - Registered. At the edge where the tracking tail (stage PIPE_LAT) is valid:
    - out_valid <= 1;
    - out_id and out_tag <= tail fields;
    - out_hsv <= {core_h, core_s, core_v}.
  - Otherwise out_valid <= 0; out_id, out_tag and out_hsv hold their last value.
  - Latency: out_valid is high on the PIPE_LAT+1-th rising edge after the accepting edge.
  - Order is preserved globally.
  - Consumers must accept every result; there is no output backpressure.
- Counter:
  - in_flight +1 on a transfer and −1 on out_valid-producing edges. Both on one edge: unchanged.
  - Maximum value is PIPE_LAT+1. It never wraps.
- Pause mid-stream: the current edge's transfer, if any, completes. From the next cycle no grants occur, and accepted samples still emerge with correct tags.
- Reset:
  - Clears every tracking valid, in_flight, out_valid, core_r/g/b, out_id, out_tag and out_hsv to 0, and sets last_grant to 1.
  - Samples in flight at reset are discarded. Their stale core outputs must never produce out_valid.
  - readies are low while reset is high.

Decomposition:
- Shared package hsv_pkg holds:
  - constant HSV_PIPE_LAT = 22, used as the PIPE_LAT default;
  - RGB/HSV field widths (8);
  - packed type for {valid, id, tag}.
- One natural sub-module: hsv_tag_delay, a parameterised depth × width shift register with synchronous clear, used for the tracking pipe.
- The rgb2hsv core is instantiated by the parent, not inside this block.

Test Plan:
- Single sample: req0 rgb=FF0000, tag=0x00123, accepted at edge T -> out_valid only at edge T+23, out_id=0, tag=0x00123, hsv=00FFFF. Next, 00FF00 -> h=0x55; 0000FF -> h=0xAA.
- Contention: both valid continuously for 10 cycles -> grants alternate 0,1,0,1…, starting with requester 0. Results return in issue order with matching id/tag. in_flight peaks at 10, then returns to 0 and idle goes high.
- Black/grey: rgb=000000 -> hsv=000000; rgb=808080 -> s=0, v=0x80, h=0.
- Pause: assert pause for 5 cycles during back-to-back req0 traffic -> no readies for those 5 cycles. The 5 result slots are gaps with out_valid=0. Samples accepted before the pause still return at T+23.
- Reset mid-operation: reset for 1 cycle with 8 samples in flight -> no out_valid for any pre-reset sample, and in_flight=0 after reset. A sample accepted right after reset returns at +23 correctly.
- Sustained full rate: req0 valid every cycle, req1 idle for 100 cycles -> 100 consecutive out_valid pulses, in_flight constant at 23 in steady state, no lost or duplicated tags.
